// File: rtl/output_serializer_axis_if.sv
// Valid/ready packet stream leaving the output serializer.
// The master drives data, valid, last and index; the slave drives ready.
interface output_serializer_axis_if #(
    parameter int OUT_W = 32,
    parameter int IW    = 3
);
    logic [OUT_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic [IW-1:0]    m_index;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        output m_index,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        input  m_index,
        output m_ready
    );
endinterface

// File: rtl/output_serializer_axis.sv
// Output serializer: snapshots LANES signed accumulator results on the falling
// edge of load_data and streams them as OUT_W-bit packets over a valid/ready
// interface, counting captures lost to overlapping load windows.
// Optional feature macro: SERIALIZER_SAT_EN -- when defined, each lane is
// saturated to the signed DATA_W range before packing; otherwise it is
// truncated to its low DATA_W bits.
module output_serializer_axis #(
    parameter int LANES  = 16,
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_data,
    input  logic [LANES*(DATA_W+1)-1:0]   lanes_in,
    output_serializer_axis_if.master      m,
    output logic                          busy,
    output logic [7:0]                    drop_count
);
    localparam int LW   = DATA_W + 1;
    localparam int PPW  = OUT_W / DATA_W;
    localparam int NPKT = LANES / PPW;
    localparam int IW   = (NPKT > 1) ? $clog2(NPKT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NPKT - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                    state, state_d;
    logic [IW-1:0]             idx, idx_d;
    logic                      load_q;
    logic [LANES*LW-1:0]       snapshot;
    logic [LANES*DATA_W-1:0]   red_flat;
    logic                      fall, streaming, hs, at_last;
    logic                      capture, drop;

    assign fall      = load_q & ~load_data;
    assign streaming = (state == ST_STREAM);
    assign hs        = streaming & m.m_ready;
    assign at_last   = (idx == LAST_IDX);

    // Next-state logic: capture, index advance, and overlap/drop decisions.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d = state;
        idx_d   = idx;
        capture = 1'b0;
        drop    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (fall) begin
                    capture = 1'b1;
                    state_d = ST_STREAM;
                    idx_d   = '0;
                end
            end
            ST_STREAM: begin
                if (hs && at_last) begin
                    // A fall on the final handshake starts the next stream with no gap.
                    idx_d = '0;
                    if (fall) begin
                        capture = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (hs) begin
                        idx_d = idx + IW'(1);
                    end
                    if (fall) begin
                        drop = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State, index, edge detector, snapshot and drop counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            load_q     <= 1'b0;
            drop_count <= '0;
            // NOTE: the snapshot is reset too, so m_data and the array start from a defined zero.
            snapshot   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state  <= state_d;
            idx    <= idx_d;
            load_q <= load_data;
            if (capture) begin
                snapshot <= lanes_in;
            end
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

`ifdef SERIALIZER_SAT_EN
    // Lane reduction: clamp each DATA_W+1 bit lane into the signed DATA_W range.
    always_comb begin
        red_flat = '0;
        for (int i = 0; i < LANES; i++) begin
            if (snapshot[i*LW + DATA_W] != snapshot[i*LW + DATA_W - 1]) begin
                red_flat[i*DATA_W +: DATA_W] = {snapshot[i*LW + DATA_W],
                                                {(DATA_W-1){~snapshot[i*LW + DATA_W]}}};
            end else begin
                red_flat[i*DATA_W +: DATA_W] = snapshot[i*LW +: DATA_W];
            end
        end
    end
`else
    logic unused_sign_bits;

    // Lane reduction: keep the low DATA_W bits of each lane.
    always_comb begin
        red_flat         = '0;
        unused_sign_bits = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            red_flat[i*DATA_W +: DATA_W] = snapshot[i*LW +: DATA_W];
            unused_sign_bits = unused_sign_bits ^ snapshot[i*LW + DATA_W];
        end
    end
`endif

    // Packet k is a contiguous OUT_W slice of the reduced lanes, lowest lane in the LSBs.
    assign m.m_data  = streaming ? red_flat[idx*OUT_W +: OUT_W] : '0;
    assign m.m_valid = streaming;
    assign m.m_last  = streaming & at_last;
    assign m.m_index = streaming ? idx : '0;
    assign busy      = streaming;

endmodule
